// File: rtl/seq_mac_alu_pkg.sv
// seq_mac_alu shared definitions.
// Operation codes, FSM states and default width.
package seq_mac_alu_pkg;

    localparam int DATA_WIDTH_DEF = 32;

    localparam logic [3:0] OP_AND      = 4'b0000;
    localparam logic [3:0] OP_OR       = 4'b0001;
    localparam logic [3:0] OP_NOR      = 4'b0010;
    localparam logic [3:0] OP_ADD      = 4'b0011;
    localparam logic [3:0] OP_SUB      = 4'b0100;
    localparam logic [3:0] OP_INC      = 4'b1111;
    localparam logic [3:0] OP_MULTPLUS = 4'b1010;
    localparam logic [3:0] OP_DEFAULT  = 4'b1001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_mac_alu_if.sv
// seq_mac_alu request/result bundle.
// master drives the request, slave is the ALU.
interface seq_mac_alu_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [3:0]            ALUOperation;
    logic [DATA_WIDTH-1:0] A;
    logic [DATA_WIDTH-1:0] B;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic                  Zero;
    logic                  busy;
    logic                  done;

    modport master (
        output start, ALUOperation, A, B,
        input  ALUResult, Zero, busy, done
    );

    modport slave (
        input  start, ALUOperation, A, B,
        output ALUResult, Zero, busy, done
    );
endinterface

// File: rtl/seq_mac_alu_shift_add_multiplier.sv
// Shift-add multiplier, one multiplier bit per cycle.
// done_o marks the cycle of the final iteration.
module shift_add_multiplier #(
    parameter int DATA_WIDTH = 32,
    parameter int MUL_CYCLES = DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);
    localparam int CW = $clog2(MUL_CYCLES + 1);

    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  run_q, run_d;

    assign done_o    = run_q && (cnt_q == CW'(MUL_CYCLES - 1));
    assign product_o = prod_q;

    // Latch operands on start, then add-and-shift each cycle.
    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        run_d    = run_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            prod_d   = '0;
            cnt_d    = '0;
            run_d    = 1'b1;
        end else if (run_q) begin
            if (mplier_q[0]) begin
                prod_d = prod_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (done_o) begin
                run_d = 1'b0;
            end
        end
    end

    // Iteration state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
        end
    end

endmodule

// File: rtl/seq_mac_alu.sv
// Execute-stage ALU with multi-cycle multiply-accumulate.
// Accumulator survives across MULTPLUS ops until reset.
module seq_mac_alu
    import seq_mac_alu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MUL_CYCLES = DATA_WIDTH
) (
    input  logic         clk,
    input  logic         reset,
    seq_mac_alu_if.slave bus
);
    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic                  zero_q, zero_d;
    logic                  done_q, done_d;
    logic [DATA_WIDTH-1:0] op_res;
    logic [DATA_WIDTH-1:0] mac_sum;
    logic [DATA_WIDTH-1:0] mul_prod;
    logic                  mul_start;
    logic                  mul_last;

    shift_add_multiplier #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (bus.A),
        .b_i       (bus.B),
        .done_o    (mul_last),
        .product_o (mul_prod)
    );

    assign mac_sum = acc_q + mul_prod;

    // Single-cycle operation mux.
    always_comb begin
        op_res = '0;
        unique case (bus.ALUOperation)
            OP_AND:     op_res = bus.A & bus.B;
            OP_OR:      op_res = bus.A | bus.B;
            OP_NOR:     op_res = ~(bus.A | bus.B);
            OP_ADD:     op_res = bus.A + bus.B;
            OP_SUB:     op_res = bus.A - bus.B;
            OP_INC:     op_res = bus.A + DATA_WIDTH'(1);
            OP_DEFAULT: op_res = '0;
            default:    op_res = '0;
        endcase
    end

    // Next state, result and accumulator updates.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        acc_d     = acc_q;
        done_d    = 1'b0;
        mul_start = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.ALUOperation == OP_MULTPLUS) begin
                        mul_start = 1'b1;
                        state_d   = ST_MUL;
                    end else begin
                        result_d = op_res;
                        zero_d   = (op_res == '0);
                        done_d   = 1'b1;
                    end
                end
            end
            ST_MUL: begin
                if (mul_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                acc_d    = mac_sum;
                result_d = mac_sum;
                zero_d   = (mac_sum == '0);
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b1;
            acc_q    <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
        end
    end

    assign bus.ALUResult = result_q;
    assign bus.Zero      = zero_q;
    assign bus.done      = done_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_mac_alu.sv
// Self-checking bench for seq_mac_alu.
// Random ops against an arithmetic reference model.
module tb_seq_mac_alu;
    import seq_mac_alu_pkg::*;

    localparam int DW  = 32;
    localparam int MC  = 32;
    localparam int LAT = MC + 2;

    logic clk;
    logic reset;
    int   n_chk;
    int   n_err;
    logic [DW-1:0] acc_m;

    seq_mac_alu_if #(.DATA_WIDTH(DW)) bus ();

    seq_mac_alu #(
        .DATA_WIDTH (DW),
        .MUL_CYCLES (MC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: what the op should produce, updating the model accumulator.
    task automatic ref_op(input logic [3:0] op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, output logic [DW-1:0] r);
        case (op)
            4'b0000: r = a & b;
            4'b0001: r = a | b;
            4'b0010: r = ~(a | b);
            4'b0011: r = a + b;
            4'b0100: r = a - b;
            4'b1111: r = a + 1;
            4'b1010: begin
                acc_m = acc_m + a * b;
                r = acc_m;
            end
            default: r = '0;
        endcase
    endtask

    // Called at a negedge; returns at the negedge where done is seen.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                          input bit junk);
        logic [DW-1:0] exp;
        int edges;
        int exp_lat;
        exp_lat = (op == 4'b1010) ? LAT : 1;
        ref_op(op, a, b, exp);
        bus.start = 1'b1;
        bus.ALUOperation = op;
        bus.A = a;
        bus.B = b;
        @(posedge clk);
        edges = 1;
        @(negedge clk);
        bus.start = 1'b0;
        if (op == 4'b1010) check({tag, "_busy"}, 64'(bus.busy), 64'(1));
        while (!bus.done && edges < 80) begin
            if (junk) begin
                bus.start = ($urandom_range(0, 2) == 0);
                bus.ALUOperation = 4'($urandom);
                bus.A = $urandom;
                bus.B = $urandom;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        bus.start = 1'b0;
        check({tag, "_lat"}, 64'(edges), 64'(exp_lat));
        check({tag, "_res"}, 64'(bus.ALUResult), 64'(exp));
        check({tag, "_zero"}, 64'(bus.Zero), 64'(exp == '0));
        check({tag, "_nbusy"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic idle_chk(input string tag);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_done0"}, 64'(bus.done), 64'(0));
        check({tag, "_busy0"}, 64'(bus.busy), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc_m = '0;
    endtask

    initial begin
        logic [3:0] ops [9];
        logic [3:0] op;
        logic [DW-1:0] ra, rb;
        n_chk = 0;
        n_err = 0;
        acc_m = '0;
        ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010;
        ops[3] = 4'b0011; ops[4] = 4'b0100; ops[5] = 4'b1111;
        ops[6] = 4'b1001; ops[7] = 4'b0110; ops[8] = 4'b1010;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.ALUOperation = '0;
        bus.A = '0;
        bus.B = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_res", 64'(bus.ALUResult), 64'(0));
        check("rst_zero", 64'(bus.Zero), 64'(1));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        reset = 1'b0;

        run_op("add", OP_ADD, 32'd5, 32'd7, 1'b0);
        check("add_val", 64'(bus.ALUResult), 64'(12));
        idle_chk("add");
        run_op("sub", OP_SUB, 32'd9, 32'd9, 1'b0);
        idle_chk("sub");
        run_op("inc", OP_INC, 32'hFFFF_FFFF, 32'd0, 1'b0);
        check("inc_wrap", 64'(bus.ALUResult), 64'(0));
        idle_chk("inc");

        do_reset();
        run_op("mac1", OP_MULTPLUS, 32'd3, 32'd4, 1'b1);
        check("mac1_val", 64'(bus.ALUResult), 64'(12));
        idle_chk("mac1");
        run_op("mac2", OP_MULTPLUS, 32'd2, 32'd5, 1'b1);
        check("mac2_val", 64'(bus.ALUResult), 64'(22));
        idle_chk("mac2");

        bus.start = 1'b1;
        bus.ALUOperation = OP_MULTPLUS;
        bus.A = 32'd7;
        bus.B = 32'd7;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        acc_m = '0;
        check("abort_busy", 64'(bus.busy), 64'(0));
        check("abort_done", 64'(bus.done), 64'(0));
        check("abort_res", 64'(bus.ALUResult), 64'(0));
        check("abort_zero", 64'(bus.Zero), 64'(1));
        idle_chk("abort");
        run_op("mac3", OP_MULTPLUS, 32'd1, 32'd1, 1'b0);
        check("mac3_val", 64'(bus.ALUResult), 64'(1));
        idle_chk("mac3");

        run_op("dflt", OP_DEFAULT, 32'hFFFF, 32'hFFFF, 1'b0);
        run_op("b2b_add", OP_ADD, 32'd10, 32'd20, 1'b0);
        run_op("b2b_mac", OP_MULTPLUS, 32'd6, 32'd0, 1'b0);
        run_op("b2b_and", OP_AND, 32'hF0F0, 32'hFF00, 1'b0);
        idle_chk("b2b");

        for (int i = 0; i < 40; i++) begin
            op = ops[$urandom_range(0, 8)];
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 3) == 0) rb = '0;
            run_op("rnd", op, ra, rb, 1'b1);
            if ($urandom_range(0, 1) == 0) idle_chk("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mac_alu.md
Name: seq_mac_alu

Overview:
- Execute-stage ALU, directly downstream of the ALU control decoder; consumes its 4-bit ALUOperation code plus operands A/B from the register file / immediate mux.
- Single-cycle logic ops, ADD, SUB and INC complete in one registered cycle.
- MULTPLUS (code 1010) is a multi-cycle shift-add multiply-accumulate into an internal accumulator.
- Asserts busy so the pipeline/PC logic can stall while a multiply is in flight.

Parameters:
- DATA_WIDTH, 32, operand/result/accumulator width.
- MUL_CYCLES, DATA_WIDTH, shift-add iterations; one multiplier bit per cycle.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only when busy=0.
- ALUOperation  input  4  operation code from the ALU control decoder.
- A  input  DATA_WIDTH  operand A.
- B  input  DATA_WIDTH  operand B.
- ALUResult  output  DATA_WIDTH  registered result; holds its value until the next completion.
- Zero  output  1  registered, =1 when ALUResult==0; updated together with ALUResult.
- busy  output  1  high from the edge after an accepted MULTPLUS start until done.
- done  output  1  one-cycle pulse when ALUResult/Zero have been updated.

Behaviour:
- Interface rule (already decided): one clock, clk; reset is synchronous and active-high, port named reset.
- Reset, on any clk edge with reset=1, overrides everything:
  - ALUResult=0, Zero=1, busy=0, done=0, accumulator=0, state=IDLE.
  - Aborts any multiply in progress; no done pulse is produced for it.
- Operation codes:
  - 0000 AND: A&B.
  - 0001 OR: A|B.
  - 0010 NOR: ~(A|B).
  - 0011 ADD: A+B.
  - 0100 SUB: A−B (branch compare).
  - 1111 INC: A+1.
  - 1010 MULTPLUS: acc + A*B.
  - Any other code (incl. 1001): result 0.
- Arithmetic: all results are modulo 2^DATA_WIDTH. Overflow and carry are discarded; no flags besides Zero.
- FSM states IDLE, MUL, FIN.
- IDLE, start=1, code≠1010:
  - At that edge: ALUResult and Zero update, done=1 for the next cycle, remain in IDLE.
  - Latency 1 edge.
- IDLE, start=1, code=1010:
  - At that edge, latch A into multiplicand and B into multiplier; clear the partial product; count=0; busy=1; go to MUL.
- MUL, each edge:
  - If multiplier[0], partial += multiplicand.
  - Multiplicand <<=1, multiplier >>=1, count++.
  - After MUL_CYCLES edges, go to FIN.
- FIN, one edge:
  - ALUResult = acc + partial (low DATA_WIDTH bits); acc updated to the same value; Zero updated.
  - done=1, busy=0, return to IDLE.
  - Total latency MUL_CYCLES+2 edges from the start edge (34 at default).
- busy rules:
  - start is ignored while busy=1.
  - A/B/ALUOperation changes during busy have no effect, since operands are latched.
- The accumulator persists across MULTPLUS operations. Only reset clears it; other ops neither read nor modify it.
- done is exactly one cycle wide. start may be asserted in the same cycle done is high (FSM is in IDLE), giving back-to-back operation.
- Multiplier=0 still runs the full MUL_CYCLES (fixed latency, no early exit).

Decomposition:
- Shared package holds:
  - ALU operation code localparams: AND, OR, NOR, ADD, SUB, INC, MULTPLUS, DEFAULT.
  - FSM state encodings.
  - DATA_WIDTH default.
- The ALU control decoder imports the same codes.
- Sub-module shift_add_multiplier: latched operands, iteration counter, partial product; start/done handshake; low DATA_WIDTH product bits.
- Top level holds the op mux, accumulator, result/Zero registers and FSM.

Test Plan:
- Reset then ADD, A=5, B=7, start one cycle -> next edge ALUResult=12, Zero=0, done=1 for one cycle, busy stays 0.
- SUB, A=9, B=9 -> ALUResult=0, Zero=1. Then INC, A=0xFFFFFFFF -> ALUResult=0, Zero=1 (wrap).
- After reset: MULTPLUS A=3, B=4 -> busy high, done exactly 34 edges later with ALUResult=12. Then MULTPLUS A=2, B=5 -> ALUResult=22 (accumulated).
- During MULTPLUS busy: pulse start with ADD 1+1 and change A/B -> ignored; final result is unaffected; no extra done.
- Reset asserted at the 10th MUL cycle -> next edge busy=0, done=0, ALUResult=0. Then MULTPLUS A=1, B=1 -> ALUResult=1 (accumulator was cleared).
- ALUOperation=1001 with A=0xFFFF, B=0xFFFF -> ALUResult=0, Zero=1. Back-to-back start on the done cycle -> accepted, completes normally.
